// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the data memory controller.
//   - byte-lane count and address offset width for the default 32-bit word,
//     plus helper functions so a parameterised instance can derive its own
//   - FSM state encoding {CLEAR, IDLE}
//   - error-cause encoding, kept as a named type for debug visibility
package mem_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_LANES  = MEM_DATA_W / 8;
  localparam int MEM_OFF_W  = $clog2(MEM_LANES);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_cause_t;

  function automatic int lanes_f(input int data_w);
    return data_w / 8;
  endfunction

  // An 8-bit word has a single lane and therefore no offset bits.
  function automatic int off_w_f(input int data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 0;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: response delay line of the data memory controller.
// One register stage by default; with MEM_OUTREG_EN defined a second stage
// is added (latency 2, throughput unchanged). Reset clears every stage.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   in_valid/in_rdata/in_err     response computed at the accept edge
//   rsp_valid/rsp_rdata/rsp_err  registered response outputs
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic              in_err,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_rdata;
  logic              s1_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_rdata <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_rdata <= in_rdata;
      s1_err   <= in_err;
    end
  end

`ifdef MEM_OUTREG_EN
  logic              s2_valid;
  logic [DATA_W-1:0] s2_rdata;
  logic              s2_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_rdata <= '0;
      s2_err   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_rdata <= s1_rdata;
      s2_err   <= s1_err;
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_rdata = s2_rdata;
  assign rsp_err   = s2_err;
`else
  assign rsp_valid = s1_valid;
  assign rsp_rdata = s1_rdata;
  assign rsp_err   = s1_err;
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: synchronous data memory with valid/ready requests,
// per-byte write enables, alignment/range error reporting and a hardware
// clear of the whole array after every reset.
// Optional feature: MEM_OUTREG_EN adds a second response register (L=2).
//
// state | meaning
// CLEAR | writing zero to word[clr_cnt], one word per cycle; no requests
// IDLE  | accepting one request per cycle; left only through reset
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   req_valid/ready  request handshake, accept on req_valid & req_ready
//   req_wr           1=write, 0=read
//   req_addr         byte address
//   req_wdata/be     write data and byte-lane enables
//   rsp_valid        one-cycle response pulse, L cycles after accept
//   rsp_rdata        read data, 0 on writes and errors
//   rsp_err          misaligned or out-of-range request
//   init_busy        clear sequence in progress
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 28,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int LANES = lanes_f(DATA_W);
  localparam int OFF   = off_w_f(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  // Mask form avoids slicing zero bits when OFF is 0.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic              clr_last;

  logic              accept, misalign, in_range, wr_ok;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  err_cause_t        err_cause;
  logic              d_valid, d_err;
  logic [DATA_W-1:0] d_rdata;

  assign clr_last = (clr_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_last) state_nxt = IDLE;
  end

  always_comb begin
    req_ready = (state == IDLE);
    init_busy = (state == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst)                           clr_cnt <= '0;
    else if (state == CLEAR && !clr_last) clr_cnt <= clr_cnt + 1'b1;
  end

  always_comb begin
    accept   = req_valid & req_ready;
    word_idx = req_addr >> OFF;
    mem_idx  = word_idx[IDX_W-1:0];
    misalign = (req_addr & OFF_MASK) != '0;
    in_range = {1'b0, word_idx} < DEPTH_X;
    if (misalign)      err_cause = ERR_MISALIGN;
    else if (!in_range) err_cause = ERR_RANGE;
    else               err_cause = ERR_NONE;
    wr_ok   = accept & req_wr & (err_cause == ERR_NONE);
    d_valid = accept;
    d_err   = accept & (err_cause != ERR_NONE);
    // Array is read combinationally and captured at the accept edge, so a
    // write on the same edge is not yet visible (read-old-data).
    d_rdata = (accept & ~req_wr & (err_cause == ERR_NONE)) ? mem[mem_idx] : '0;
  end

  // Storage has no reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < LANES; i++) begin
          if (req_be[i]) mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  mem_resp_pipe #(.DATA_W(DATA_W)) u_resp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_valid),
    .in_rdata  (d_rdata),
    .in_err    (d_err),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl.
// Honors MEM_OUTREG_EN for the expected response latency.
module tb_data_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 28;
  localparam int DEPTH  = 256;
`ifdef MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;
  rsp_t rq[$];

  // Back-to-back stimulus table
  logic        p_wr   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [27:0] p_addr [5] = '{28'h8, 28'h8, 28'h14, 28'h8, 28'h8};
  logic [31:0] p_wd   [5] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] p_exp  [5] = '{32'h0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0, 32'h0};

  data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rsp_valid) rq.push_back('{rsp_rdata, rsp_err, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_clear(input string tag);
    int  n;
    bit  rdy_seen;
    n = 0;
    rdy_seen = 0;
    while (init_busy && n < 1000) begin
      if (req_ready) rdy_seen = 1;
      n++;
      tick();
    end
    chk({tag, "_len"}, n, DEPTH);
    chk({tag, "_ready_low"}, rdy_seen, 0);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [27:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err);
    int k;
    bit got;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    k = 1;
    got = 0;
    while (k <= 4 && !got) begin
      if (rsp_valid) got = 1;
      else begin
        tick();
        k++;
      end
    end
    chk({tag, "_seen"}, got, 1);
    if (got) begin
      chk({tag, "_lat"}, k, LAT);
      chk({tag, "_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_err"}, rsp_err, exp_err);
    end
    tick();
    chk({tag, "_pulse_end"}, rsp_valid, 0);
    chk({tag, "_idle_rdata"}, rsp_rdata, 0);
  endtask

  initial begin
    int acc0;
    int acc1;
    int late;

    repeat (5) tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", init_busy, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    rst = 1'b1;
    chk_clear("clr1");

    do_req("rd_000", 1'b0, 28'h0,   32'h0, 4'h0, 32'h0, 1'b0);
    do_req("rd_3fc", 1'b0, 28'h3FC, 32'h0, 4'h0, 32'h0, 1'b0);
    do_req("rd_200", 1'b0, 28'h200, 32'h0, 4'h0, 32'h0, 1'b0);

    do_req("wr_014", 1'b1, 28'h14, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    do_req("rd_014", 1'b0, 28'h14, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

    do_req("wr_020a", 1'b1, 28'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    do_req("wr_020b", 1'b1, 28'h20, 32'hFFFFFFFF, 4'b0101, 32'h0, 1'b0);
    do_req("rd_020",  1'b0, 28'h20, 32'h0, 4'h0, 32'h11FF33FF, 1'b0);
    do_req("wr_020z", 1'b1, 28'h20, 32'h99999999, 4'h0, 32'h0, 1'b0);
    do_req("rd_020z", 1'b0, 28'h20, 32'h0, 4'h0, 32'h11FF33FF, 1'b0);

    do_req("rd_016_mis", 1'b0, 28'h16,  32'h0, 4'h0, 32'h0, 1'b1);
    do_req("wr_400_oor", 1'b1, 28'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
    do_req("rd_000_aft", 1'b0, 28'h0,   32'h0, 4'h0, 32'h0, 1'b0);

    rq.delete();
    acc0 = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_wr    = p_wr[i];
      req_addr  = p_addr[i];
      req_wdata = p_wd[i];
      req_be    = 4'hF;
      tick();
      if (i == 0) acc0 = cyc;
    end
    req_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("pipe_count", rq.size(), 5);
    for (int i = 0; i < 5 && i < rq.size(); i++) begin
      chk($sformatf("pipe%0d_rdata", i), rq[i].rdata, p_exp[i]);
      chk($sformatf("pipe%0d_err", i), rq[i].err, 0);
      chk($sformatf("pipe%0d_cyc", i), rq[i].cyc, acc0 + LAT - 1 + i);
    end

    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 28'h14;
    tick();
    acc1 = cyc;
    req_valid = 1'b0;
    rst = 1'b0;
    rq.delete();
    tick();
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", init_busy, 1);
    rst = 1'b1;
    chk_clear("clr2");
    late = 0;
    foreach (rq[i]) if (rq[i].cyc > acc1) late++;
    chk("mid_rst_no_rsp", late, 0);
    do_req("rd_014_clr", 1'b0, 28'h14, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
